hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core, with branch/jump resolution in ID.
- Consumes the ID-stage decode sideband (hazard_optype, rs1use, rs2use, register indices, Branch).
- Keeps its own EX/MEM/WB shadow of each in-flight instruction's optype and rd.
- Drives PC/pipeline-register enables, flushes, and ID/EX forwarding selects; also counts load-use stall and branch-flush cycles.

Parameters:
CNT_W, 32, width of the two performance counters (wrap on overflow).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_ext  in  1  memory wait; freezes the whole pipeline.
rs1_ID  in  5  rs1 index of the ID instruction.
rs2_ID  in  5  rs2 index of the ID instruction.
rd_ID  in  5  rd index of the ID instruction.
rs1use_ID  in  1  ID instruction reads rs1.
rs2use_ID  in  1  ID instruction reads rs2.
hazard_optype_ID  in  2  encoding: 00 none, 01 ALU-type write, 10 load, 11 store.
Branch_ID  in  1  taken branch/jump in ID (already ANDed with the compare result).
PC_EN_IF  out  1  PC update enable.
reg_FD_EN  out  1  IF/ID register enable.
reg_FD_stall  out  1  IF/ID hold.
reg_FD_flush  out  1  IF/ID squash.
reg_DE_EN  out  1  ID/EX register enable.
reg_DE_flush  out  1  ID/EX bubble insert.
reg_EM_EN  out  1  EX/MEM register enable.
reg_MW_EN  out  1  MEM/WB register enable.
forward_ctrl_A  out  2  rs1 source in ID: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
forward_ctrl_B  out  2  rs2 source in ID, same encoding as forward_ctrl_A.
forward_ctrl_ls  out  1  store in EX takes its store data from the load result now in MEM/WB.
stall_cnt  out  CNT_W  number of load-use stall cycles.
flush_cnt  out  CNT_W  number of branch-flush cycles.

Behaviour:
- Shadow registers (EX, MEM, WB stages):
  - Each holds {optype[1:0], rd[4:0]}; the EX shadow also holds rs2[4:0].
  - rst clears all fields to 0 and both counters to 0.
- Advance: on each rising edge with stall_ext=0, EX<-ID, MEM<-EX, WB<-MEM.
  - If a load-use stall is active, EX<-{00,0,0} (bubble).
  - With stall_ext=1 every shadow register and counter holds.
- Match rule:
  - A source rsX hits stage S when rsXuse_ID=1, rsX!=0, S.rd==rsX, and S.optype is 01 or 10.
  - Stores (11) and none (00) never match.
- Load-use stall (ls):
  - Asserted when an ID source hits EX with EX.optype=10.
  - Exception: if the ID op is a store (11) and only rs2 hits, there is no stall.
- Forward select, per source:
  - Priority is nearest first: EX hit with optype 01 gives 1; otherwise a MEM hit gives 2 (optype 01) or 3 (optype 10); otherwise 0.
  - WB never forwards. The regfile is write-before-read, so WB-to-ID needs no bypass.
  - The store-rs2 exception case above gives forward_ctrl_B=0.
- forward_ctrl_ls = (EX.optype==11) & (EX.rs2!=0) & (MEM.optype==10) & (MEM.rd==EX.rs2).
  - Computed from the registered shadows only.
- Outputs are combinational from inputs and shadows, with fixed priority:
  - stall_ext=1: all enables 0, all flushes 0. This overrides everything below.
  - else ls=1: PC_EN_IF=0, reg_FD_EN=1, reg_FD_stall=1, reg_DE_flush=1, reg_FD_flush=0. Branch_ID is ignored because operands are stale.
  - else Branch_ID=1: reg_FD_flush=1 (one-slot squash), PC_EN_IF=1.
  - Otherwise: all enables 1, stall and flush 0.
  - reg_DE_EN, reg_EM_EN and reg_MW_EN are 1 unless stall_ext=1.
- Counters, both gated by stall_ext=0:
  - stall_cnt increments on edges with ls=1.
  - flush_cnt increments on edges where the branch flush actually applies.
- Reset values:
  - All shadows are 0, so forward_ctrl_A = forward_ctrl_B = 0, forward_ctrl_ls = 0, and all flushes/stall are 0.
  - Enables are 1 unless stall_ext=1.
- Reset mid-operation clears in-flight shadows immediately (async). The first post-reset instruction sees no hazards.
- Simultaneous events:
  - ls and a match on the other source: stall only. Forward selects are still output but are don't-care.
  - Both sources hit: each is resolved independently.

Test Plan:
- Back-to-back ALU, `addi x5,x0,1` then `add x6,x5,x5`: second op in ID gives forward_ctrl_A = forward_ctrl_B = 1, no stall.
- Load-use, `lw x7,0(x0)` then `add x8,x7,x0`:
  - Cycle 1: PC_EN_IF=0, reg_FD_stall=1, reg_DE_flush=1, stall_cnt 0 to 1.
  - Next cycle: forward_ctrl_A=3.
- Load-then-store, `lw x9` then `sw x9,4(x0)`: no stall; two cycles later forward_ctrl_ls=1.
- Taken `beq` in ID (Branch_ID=1, no hazard) gives reg_FD_flush=1 and flush_cnt+1. The same beq with a load-use on rs1 gives the stall only, with reg_FD_flush=0.
- x0 guard, `addi x0,x0,5` then `add x1,x0,x0`: forward_ctrl_A = forward_ctrl_B = 0.
- stall_ext=1 for 3 cycles mid-sequence: all enables 0, shadows/counters unchanged. Then assert rst during a stall: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage decode sideband in, pipeline controls out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_ext;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_ID;
    logic             rs1use_ID;
    logic             rs2use_ID;
    logic [1:0]       hazard_optype_ID;
    logic             Branch_ID;
    logic             PC_EN_IF;
    logic             reg_FD_EN;
    logic             reg_FD_stall;
    logic             reg_FD_flush;
    logic             reg_DE_EN;
    logic             reg_DE_flush;
    logic             reg_EM_EN;
    logic             reg_MW_EN;
    logic [1:0]       forward_ctrl_A;
    logic [1:0]       forward_ctrl_B;
    logic             forward_ctrl_ls;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: drives decode sideband, observes controls.
    modport master (
        output stall_ext, rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID,
               hazard_optype_ID, Branch_ID,
        input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN,
               reg_DE_flush, reg_EM_EN, reg_MW_EN, forward_ctrl_A,
               forward_ctrl_B, forward_ctrl_ls, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  stall_ext, rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID,
               hazard_optype_ID, Branch_ID,
        output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN,
               reg_DE_flush, reg_EM_EN, reg_MW_EN, forward_ctrl_A,
               forward_ctrl_B, forward_ctrl_ls, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline with branch resolution in ID.
// Tracks optype/rd of instructions in EX/MEM/WB, raises load-use stalls,
// selects ID-stage forwarding, squashes IF/ID on taken branches and counts
// stall / flush cycles.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rd;
    } shadow_t;

    // stage[0] = EX, stage[1] = MEM, stage[2] = WB
    shadow_t    stage [3];
    logic [4:0] ex_rs2;

    logic [4:0] src_idx  [2];
    logic       src_use  [2];
    logic       hit_ex   [2];
    logic       hit_mem  [2];
    logic       load_hit [2];
    logic [1:0] fwd      [2];

    logic store_id;
    logic ls;
    logic branch_flush;

    assign src_idx[0] = bus.rs1_ID;
    assign src_idx[1] = bus.rs2_ID;
    assign src_use[0] = bus.rs1use_ID;
    assign src_use[1] = bus.rs2use_ID;
    assign store_id   = (bus.hazard_optype_ID == OP_STORE);

    // Per-source match against EX and MEM; stores and empty slots never match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign hit_ex[gi]  = src_use[gi] && (src_idx[gi] != 5'd0) &&
                             (stage[0].rd == src_idx[gi]) &&
                             ((stage[0].op == OP_ALU) || (stage[0].op == OP_LOAD));
        assign hit_mem[gi] = src_use[gi] && (src_idx[gi] != 5'd0) &&
                             (stage[1].rd == src_idx[gi]) &&
                             ((stage[1].op == OP_ALU) || (stage[1].op == OP_LOAD));
        assign load_hit[gi] = hit_ex[gi] && (stage[0].op == OP_LOAD);
        // Nearest producer wins; WB needs no bypass (write-before-read regfile).
        assign fwd[gi] = (hit_ex[gi] && (stage[0].op == OP_ALU)) ? 2'd1 :
                         hit_mem[gi] ? ((stage[1].op == OP_LOAD) ? 2'd3 : 2'd2) :
                         2'd0;
    end

    // A store whose data (rs2) comes from a load in EX picks it up later via
    // forward_ctrl_ls, so only an address (rs1) dependence stalls it.
    assign ls           = load_hit[0] || (load_hit[1] && !store_id);
    assign branch_flush = !bus.stall_ext && !ls && bus.Branch_ID;

    assign bus.forward_ctrl_A  = fwd[0];
    assign bus.forward_ctrl_B  = (store_id && load_hit[1]) ? 2'd0 : fwd[1];
    assign bus.forward_ctrl_ls = (stage[0].op == OP_STORE) && (ex_rs2 != 5'd0) &&
                                 (stage[1].op == OP_LOAD) && (stage[1].rd == ex_rs2);

    // Pipeline enables/flushes: memory freeze > load-use stall > branch squash.
    always_comb begin
        bus.PC_EN_IF     = 1'b1;
        bus.reg_FD_EN    = 1'b1;
        bus.reg_FD_stall = 1'b0;
        bus.reg_FD_flush = 1'b0;
        bus.reg_DE_EN    = 1'b1;
        bus.reg_DE_flush = 1'b0;
        bus.reg_EM_EN    = 1'b1;
        bus.reg_MW_EN    = 1'b1;
        if (bus.stall_ext) begin
            bus.PC_EN_IF  = 1'b0;
            bus.reg_FD_EN = 1'b0;
            bus.reg_DE_EN = 1'b0;
            bus.reg_EM_EN = 1'b0;
            bus.reg_MW_EN = 1'b0;
        end else if (ls) begin
            bus.PC_EN_IF     = 1'b0;
            bus.reg_FD_stall = 1'b1;
            bus.reg_DE_flush = 1'b1;
        end else if (bus.Branch_ID) begin
            bus.reg_FD_flush = 1'b1;
        end
    end

    // Shadow pipeline: advance unless frozen, bubble into EX on load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) stage[i] <= '0;
            ex_rs2 <= 5'd0;
        end else if (!bus.stall_ext) begin
            for (int i = 2; i > 0; i--) stage[i] <= stage[i-1];
            if (ls) begin
                stage[0] <= '{op: OP_NONE, rd: 5'd0};
                ex_rs2   <= 5'd0;
            end else begin
                stage[0] <= '{op: bus.hazard_optype_ID, rd: bus.rd_ID};
                ex_rs2   <= bus.rs2_ID;
            end
        end
    end

    // Performance counters, frozen together with the pipeline; wrap on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.stall_cnt <= '0;
            bus.flush_cnt <= '0;
        end else if (!bus.stall_ext) begin
            if (ls)           bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (branch_flush) bus.flush_cnt <= bus.flush_cnt + 1'b1;
        end
    end

    // WB shadow is carried for completeness of the in-flight view; it is the
    // oldest stage and never feeds a bypass.
    logic wb_valid;
    assign wb_valid = (stage[2].op != OP_NONE) || (stage[2].rd != 5'd0);
    logic unused_wb;
    assign unused_wb = wb_valid;
endmodule
